// File: rtl/scan_clk_gen.sv
// scan_clk_gen: runtime clock divider plus multiplexed display digit scanner.
//
// Optional feature macro: SCAN_DEADTIME_EN adds DEAD_CYC all-anodes-off
// cycles after each digit slot. The default build has no dead time.
//
// Ports:
//   clk        - sole clock, all state on rising edge
//   rst        - synchronous active-high reset (overrides en)
//   en         - count enable; low freezes counters and outputs
//   div_limit  - divider terminal count, divclk period = 2*(div_limit+1)
//   blank_mask - bit k = 1 blanks digit k during its slot
//   divclk     - registered divided clock, 50% duty
//   div_tick   - registered one-cycle pulse on every divclk toggle
//   AN         - registered active-low one-hot digit anodes
//   dig_idx    - index of the digit owning the current slot
module scan_clk_gen #(
   parameter int unsigned DIVW     = 26,
   parameter int unsigned NDIG     = 4,
   parameter int unsigned IDXW     = 2,
   parameter int unsigned SCAN_CNT = 131072,
   parameter int unsigned DEAD_CYC = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [DIVW-1:0] div_limit,
   input  logic [NDIG-1:0] blank_mask,
   output logic            divclk,
   output logic            div_tick,
   output logic [NDIG-1:0] AN,
   output logic [IDXW-1:0] dig_idx
);

   // One counter serves both the show and the dead phase of a slot.
   localparam int unsigned CNT_MAX = (SCAN_CNT > DEAD_CYC) ? SCAN_CNT : DEAD_CYC;
   localparam int unsigned CNTW    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNTW-1:0] SCAN_LAST = CNTW'(SCAN_CNT - 1);
`ifdef SCAN_DEADTIME_EN
   localparam logic [CNTW-1:0] DEAD_LAST = CNTW'(DEAD_CYC - 1);
`endif
   localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NDIG - 1);

   typedef enum logic {
      SHOW = 1'b0,
      DEAD = 1'b1
   } state_t;

   state_t          state, state_nx;
   logic [DIVW-1:0] div_cnt, div_cnt_nx;
   logic            divclk_nx, div_tick_nx;
   logic [CNTW-1:0] scan_cnt, scan_cnt_nx;
   logic [IDXW-1:0] dig_idx_nx, idx_inc;
   logic [NDIG-1:0] an_nx;

   // Active-low anode pattern for one digit, all-off when that digit is blanked.
   function automatic logic [NDIG-1:0] anode(input logic [IDXW-1:0] idx,
                                             input logic [NDIG-1:0] mask);
      logic [NDIG-1:0] a;
      a = '1;
      for (int unsigned k = 0; k < NDIG; k++) begin
         if ((idx == IDXW'(k)) && !mask[k]) a[k] = 1'b0;
      end
      return a;
   endfunction

   // Divider: >= compare so a lowered div_limit wraps instead of overflowing.
   always_comb begin
      div_cnt_nx  = div_cnt;
      divclk_nx   = divclk;
      div_tick_nx = 1'b0;
      if (en) begin
         if (div_cnt >= div_limit) begin
            div_cnt_nx  = '0;
            divclk_nx   = ~divclk;
            div_tick_nx = 1'b1;
         end else begin
            div_cnt_nx  = div_cnt + DIVW'(1);
         end
      end
   end

   // Scan FSM next state; AN follows the next state so AN and dig_idx stay aligned.
   always_comb begin
      state_nx    = state;
      scan_cnt_nx = scan_cnt;
      dig_idx_nx  = dig_idx;
      an_nx       = AN;
      idx_inc     = (dig_idx == IDX_LAST) ? '0 : dig_idx + IDXW'(1);
      if (en) begin
         case (state)
            SHOW: begin
               if (scan_cnt >= SCAN_LAST) begin
                  scan_cnt_nx = '0;
                  dig_idx_nx  = idx_inc;
`ifdef SCAN_DEADTIME_EN
                  state_nx    = DEAD;
`endif
               end else begin
                  scan_cnt_nx = scan_cnt + CNTW'(1);
               end
            end
            DEAD: begin
`ifdef SCAN_DEADTIME_EN
               if (scan_cnt >= DEAD_LAST) begin
                  state_nx    = SHOW;
                  scan_cnt_nx = '0;
               end else begin
                  scan_cnt_nx = scan_cnt + CNTW'(1);
               end
`else
               state_nx    = SHOW;
               scan_cnt_nx = '0;
`endif
            end
         endcase
         an_nx = (state_nx == SHOW) ? anode(dig_idx_nx, blank_mask) : '1;
      end
   end

   // All state registers; reset aborts any slot or dead time immediately.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= SHOW;
         div_cnt  <= '0;
         divclk   <= 1'b0;
         div_tick <= 1'b0;
         scan_cnt <= '0;
         dig_idx  <= '0;
         AN       <= '1;
      end else begin
         state    <= state_nx;
         div_cnt  <= div_cnt_nx;
         divclk   <= divclk_nx;
         div_tick <= div_tick_nx;
         scan_cnt <= scan_cnt_nx;
         dig_idx  <= dig_idx_nx;
         AN       <= an_nx;
      end
   end

endmodule

// File: tb/tb_scan_clk_gen.sv
// tb_scan_clk_gen: self-checking bench for scan_clk_gen (3 digits, short slots).
// Expected outputs are queued when a cycle is driven and checked after the edge.
module tb_scan_clk_gen;

   localparam int unsigned DIVW     = 8;
   localparam int unsigned NDIG     = 3;
   localparam int unsigned IDXW     = 2;
   localparam int unsigned SCAN_CNT = 4;
   localparam int unsigned DEAD_CYC = 2;
`ifdef SCAN_DEADTIME_EN
   localparam int unsigned SLOT = SCAN_CNT + DEAD_CYC;
   localparam logic [NDIG-1:0] AN_E5 = 3'b111;
   localparam logic [NDIG-1:0] AN_E9 = 3'b101;
   localparam logic [IDXW-1:0] IX_E9 = 2'd1;
`else
   localparam int unsigned SLOT = SCAN_CNT;
   localparam logic [NDIG-1:0] AN_E5 = 3'b101;
   localparam logic [NDIG-1:0] AN_E9 = 3'b011;
   localparam logic [IDXW-1:0] IX_E9 = 2'd2;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            en;
   logic [DIVW-1:0] div_limit;
   logic [NDIG-1:0] blank_mask;
   logic            divclk;
   logic            div_tick;
   logic [NDIG-1:0] AN;
   logic [IDXW-1:0] dig_idx;

   scan_clk_gen #(
      .DIVW(DIVW), .NDIG(NDIG), .IDXW(IDXW), .SCAN_CNT(SCAN_CNT), .DEAD_CYC(DEAD_CYC)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .div_limit(div_limit), .blank_mask(blank_mask),
      .divclk(divclk), .div_tick(div_tick), .AN(AN), .dig_idx(dig_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic            divclk;
      logic            div_tick;
      logic [NDIG-1:0] an;
      logic [IDXW-1:0] idx;
   } exp_t;

   typedef struct {
      logic            rst;
      logic            en;
      logic [DIVW-1:0] lim;
      logic [NDIG-1:0] mask;
      exp_t            exp;
   } vec_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   // Reference model: one position counter spanning a whole slot (show + dead).
   int              m_div, m_pos, m_dig;
   logic            m_clk, m_tick;
   logic [NDIG-1:0] m_an;

   function automatic logic [NDIG-1:0] model_an(input int dig, input bit show,
                                                input logic [NDIG-1:0] mask);
      logic [NDIG-1:0] a;
      a = '1;
      if (show && !mask[dig]) a[dig] = 1'b0;
      return a;
   endfunction

   task automatic model_update();
      if (rst) begin
         m_div = 0; m_clk = 1'b0; m_tick = 1'b0;
         m_pos = 0; m_dig = 0;    m_an   = '1;
      end else if (en) begin
         if (m_div >= int'(div_limit)) begin
            m_div = 0; m_clk = ~m_clk; m_tick = 1'b1;
         end else begin
            m_div++;   m_tick = 1'b0;
         end
         if (m_pos == int'(SCAN_CNT) - 1) m_dig = (m_dig + 1) % int'(NDIG);
         m_pos = (m_pos + 1) % int'(SLOT);
         m_an  = model_an(m_dig, m_pos < int'(SCAN_CNT), blank_mask);
      end else begin
         m_tick = 1'b0;
      end
   endtask

   function automatic exp_t model_exp();
      exp_t e;
      e.divclk   = m_clk;
      e.div_tick = m_tick;
      e.an       = m_an;
      e.idx      = IDXW'(m_dig);
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, got, want);
      end
   endtask

   task automatic check_one();
      exp_t e;
      if (exp_q.size() == 0) begin
         total++; bad++;
         $display("FAIL queue_empty cycle=%0d got=0 want=1", cyc);
         return;
      end
      e = exp_q.pop_front();
      chk("divclk",   32'(divclk),   32'(e.divclk));
      chk("div_tick", 32'(div_tick), 32'(e.div_tick));
      chk("AN",       32'(AN),       32'(e.an));
      chk("dig_idx",  32'(dig_idx),  32'(e.idx));
      total++;
      if ($countones(~AN) > 1) begin
         bad++;
         $display("FAIL an_onehot cycle=%0d got=%0b want=at_most_one_low", cyc, AN);
      end
   endtask

   // Queue the expectation for the driven inputs, clock once, then compare.
   task automatic cycle(input bit from_tbl, input exp_t tbl_exp);
      model_update();
      exp_q.push_back(from_tbl ? tbl_exp : model_exp());
      @(posedge clk);
      #1;
      cyc++;
      check_one();
   endtask

   exp_t none;
   task automatic run();
      cycle(1'b0, none);
   endtask

   function automatic vec_t mk(input logic r, input logic e, input logic [DIVW-1:0] l,
                               input logic [NDIG-1:0] m, input logic dc, input logic dt,
                               input logic [NDIG-1:0] a, input logic [IDXW-1:0] ix);
      vec_t v;
      v.rst = r; v.en = e; v.lim = l; v.mask = m;
      v.exp.divclk = dc; v.exp.div_tick = dt; v.exp.an = a; v.exp.idx = ix;
      return v;
   endfunction

   vec_t tbl[13];

   initial begin
      #200000;
      $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      none = '{default: '0};
      // Reset, then div_limit=3: first toggle on the 4th enabled edge.
      tbl[0]  = mk(1, 1, 3, 3'b000, 0, 0, 3'b111, 2'd0);
      tbl[1]  = mk(1, 1, 3, 3'b000, 0, 0, 3'b111, 2'd0);
      tbl[2]  = mk(0, 1, 3, 3'b000, 0, 0, 3'b110, 2'd0);
      tbl[3]  = mk(0, 1, 3, 3'b000, 0, 0, 3'b110, 2'd0);
      tbl[4]  = mk(0, 1, 3, 3'b000, 0, 0, 3'b110, 2'd0);
      tbl[5]  = mk(0, 1, 3, 3'b000, 1, 1, AN_E5,  2'd1);
      tbl[6]  = mk(0, 1, 3, 3'b000, 1, 0, AN_E5,  2'd1);
      tbl[7]  = mk(0, 1, 3, 3'b000, 1, 0, 3'b101, 2'd1);
      tbl[8]  = mk(0, 1, 3, 3'b000, 1, 0, 3'b101, 2'd1);
      tbl[9]  = mk(0, 1, 3, 3'b000, 0, 1, AN_E9,  IX_E9);
      tbl[10] = mk(0, 0, 3, 3'b000, 0, 0, AN_E9,  IX_E9);
      tbl[11] = mk(0, 1, 3, 3'b000, 0, 0, AN_E9,  IX_E9);
      tbl[12] = mk(1, 0, 3, 3'b000, 0, 0, 3'b111, 2'd0);

      rst = 1'b1; en = 1'b1; div_limit = 8'd3; blank_mask = '0;
      for (int i = 0; i < 13; i++) begin
         rst = tbl[i].rst; en = tbl[i].en; div_limit = tbl[i].lim; blank_mask = tbl[i].mask;
         cycle(1'b1, tbl[i].exp);
      end

      // Several full scans including the 2 -> 0 wrap.
      rst = 1'b0; en = 1'b1; div_limit = 8'd3; blank_mask = '0;
      repeat (30) run();

      // Blanking digit 1, then a mask change landing mid-slot.
      blank_mask = 3'b010;
      repeat (20) run();
      blank_mask = 3'b101;
      repeat (10) run();
      blank_mask = 3'b000;

      // Freeze mid-slot for 10 cycles, then resume.
      for (int i = 0; i < 20 && m_pos != 1; i++) run();
      en = 1'b0;
      repeat (10) run();
      en = 1'b1;
      repeat (12) run();

      // div_limit = 0: toggle and tick every cycle.
      div_limit = 8'd0;
      repeat (6) run();

      // Lower div_limit below the running count: wrap on the next edge.
      div_limit = 8'd9;
      for (int i = 0; i < 20 && m_div != 7; i++) run();
      if (m_div != 7) begin
         total++; bad++;
         $display("FAIL div_reach7 cycle=%0d got=%0d want=7", cyc, m_div);
      end
      div_limit = 8'd2;
      repeat (14) run();

      // Reset pulse in slot 2 mid-divide.
      for (int i = 0; i < 40 && !(m_dig == 2 && m_pos == 1); i++) run();
      if (!(m_dig == 2 && m_pos == 1)) begin
         total++; bad++;
         $display("FAIL slot2_reach cycle=%0d got=%0d want=2", cyc, m_dig);
      end
      rst = 1'b1;
      run();
      rst = 1'b0;
      repeat (10) run();

      // Random mix of enable, mask, limit and occasional reset.
      repeat (300) begin
         en  = ($urandom_range(0, 9) != 0);
         rst = ($urandom_range(0, 60) == 0);
         if ($urandom_range(0, 7) == 0) blank_mask = NDIG'($urandom_range(0, 7));
         if ($urandom_range(0, 15) == 0) div_limit = DIVW'($urandom_range(0, 5));
         run();
      end
      rst = 1'b0;

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
